// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - three-stage pipelined floating-point adder (flush-to-zero, truncation).
// Optional macro FPADD_SUB_EN adds a 'sub' input that negates b (computes a-b).
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
`ifdef FPADD_SUB_EN
  input  logic                   sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   ovf,
  output logic                   zero
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int MG   = MAN_W + 2;  // hidden bit + fraction + guard bit
  localparam int EMAX = (1 << EXP_W) - 1;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- S1: unpack / compare / align ----------------
  logic [W-1:0]     bx;
  logic             sa, sbx, a_nan, b_nan, a_inf, b_inf, swap;
  logic [EXP_W-1:0] ea, eb, e_big, e_sml, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [MG-1:0]    ma, mb, m_big, m_sml, m_aln;
  int               sh;

`ifdef FPADD_SUB_EN
  assign bx = {b[W-1] ^ sub, b[W-2:0]};
`else
  assign bx = b;
`endif

  assign sa    = a[W-1];
  assign sbx   = bx[W-1];
  assign ea    = a[W-2:MAN_W];
  assign eb    = bx[W-2:MAN_W];
  assign fa    = a[MAN_W-1:0];
  assign fb    = bx[MAN_W-1:0];
  assign a_nan = (&ea) && (|fa);
  assign b_nan = (&eb) && (|fb);
  assign a_inf = (&ea) && !(|fa);
  assign b_inf = (&eb) && !(|fb);
  assign ma    = (ea == '0) ? '0 : {1'b1, fa, 1'b0};
  assign mb    = (eb == '0) ? '0 : {1'b1, fb, 1'b0};
  assign swap  = {ea, ma} < {eb, mb};
  assign e_big = swap ? eb : ea;
  assign e_sml = swap ? ea : eb;
  assign m_big = swap ? mb : ma;
  assign m_sml = swap ? ma : mb;
  assign diff  = e_big - e_sml;
  assign sh    = int'(diff);
  assign m_aln = (sh >= MG) ? '0 : (m_sml >> diff);

  logic             v1, nan1, inf1, infs1, bz1, sign1, esub1;
  logic [EXP_W-1:0] exp1;
  logic [MG-1:0]    mb1, ms1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          v1 <= 1'b0;
    else if (advance) v1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      nan1  <= a_nan || b_nan || (a_inf && b_inf && (sa != sbx));
      inf1  <= a_inf || b_inf;
      infs1 <= a_inf ? sa : sbx;
      bz1   <= (ea == '0) && (eb == '0);
      // Two zeros keep a negative sign only when both are negative.
      sign1 <= ((ea == '0) && (eb == '0)) ? (sa && sbx) : (swap ? sbx : sa);
      esub1 <= sa ^ sbx;
      exp1  <= e_big;
      mb1   <= m_big;
      ms1   <= m_aln;
    end
  end

  // ---------------- S2: signed magnitude add ----------------
  logic             v2, nan2, inf2, infs2, bz2, sign2;
  logic [EXP_W-1:0] exp2;
  logic [MG:0]      sum2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          v2 <= 1'b0;
    else if (advance) v2 <= v1;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      nan2  <= nan1;
      inf2  <= inf1;
      infs2 <= infs1;
      bz2   <= bz1;
      sign2 <= sign1;
      exp2  <= exp1;
      // Base magnitude is never smaller than the aligned operand, so no borrow.
      sum2  <= esub1 ? ({1'b0, mb1} - {1'b0, ms1}) : ({1'b0, mb1} + {1'b0, ms1});
    end
  end

  // ---------------- S3: normalise / pack / flags ----------------
  logic [W-1:0]     res_c;
  logic             ovf_c, zero_c;
  logic [MAN_W-1:0] frac;
  int               p, en;

  always_comb begin
    res_c  = '0;
    ovf_c  = 1'b0;
    zero_c = 1'b0;
    p      = 0;
    for (int i = 0; i <= MG; i++) begin
      if (sum2[i]) p = i;
    end
    en   = int'(exp2) + p - (MG - 1);
    frac = MAN_W'((sum2 << (MG - p)) >> 2);
    if (nan2) begin
      res_c = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (inf2) begin
      res_c = {infs2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (bz2) begin
      res_c  = {sign2, {(W-1){1'b0}}};
      zero_c = 1'b1;
    end else if (sum2 == '0) begin
      zero_c = 1'b1;
    end else if (en >= EMAX) begin
      res_c = {sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_c = 1'b1;
    end else if (en <= 0) begin
      res_c  = {sign2, {(W-1){1'b0}}};
      zero_c = 1'b1;
    end else begin
      res_c = {sign2, EXP_W'(en), frac};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      out_valid <= v2;
      result    <= res_c;
      ovf       <= ovf_c;
      zero      <= zero_c;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb/tb_fp_add_pipe.sv - scoreboard testbench for fp_add_pipe (default single-precision parameters).
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, ovf, zero;
  logic [31:0] a, b, result;
  logic        sub_v;

  always #5 clk = ~clk;

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
`ifdef FPADD_SUB_EN
    .sub(sub_v),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .zero(zero)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  int          stall_lo = 0;
  int          stall_hi = 0;
  logic [33:0] sb_q[$];
  logic [31:0] va[20], vb[20];
  logic [33:0] vexp[20];
  logic        vsub[20];
  localparam int NV = 18;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = !((cyc >= stall_lo) && (cyc <= stall_hi));
    endcase
  end

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_valid", out_valid, 1'b0);
      end else begin
        check_eq("result", result, sb_q[0][33:2]);
        check_eq("ovf", ovf, sb_q[0][1]);
        check_eq("zero", zero, sb_q[0][0]);
        if (!out_ready) check_eq("stall_in_ready", in_ready, 1'b0);
        else void'(sb_q.pop_front());
      end
    end
  end

  task automatic send(input int idx);
    a        = va[idx];
    b        = vb[idx];
    sub_v    = vsub[idx];
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(vexp[idx]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check_eq("send_timeout", in_ready, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb_q.size() != 0; t++) @(posedge clk);
    check_eq("drain_empty", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic set_vec(input int i, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input logic o, input logic z);
    va[i] = x; vb[i] = y; vexp[i] = {r, o, z}; vsub[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    set_vec(0,  32'h3FC00000, 32'h40100000, 32'h40700000, 1'b0, 1'b0);
    set_vec(1,  32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, 1'b1);
    set_vec(2,  32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b1);
    set_vec(3,  32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0);
    set_vec(4,  32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0);
    set_vec(5,  32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    set_vec(6,  32'h40400000, 32'hBF800000, 32'h40000000, 1'b0, 1'b0);
    set_vec(7,  32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b0);
    set_vec(8,  32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0);
    set_vec(9,  32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0);
    set_vec(10, 32'h3F800000, 32'h34000000, 32'h3F800001, 1'b0, 1'b0);
    set_vec(11, 32'h3F800000, 32'hB3800000, 32'h3F7FFFFF, 1'b0, 1'b0);
    set_vec(12, 32'h00800000, 32'h80C00000, 32'h80000000, 1'b0, 1'b1);
    set_vec(13, 32'h00000001, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
    set_vec(14, 32'hC0200000, 32'h3F800000, 32'hBFC00000, 1'b0, 1'b0);
    set_vec(15, 32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 1'b0);
    set_vec(16, 32'h3F800000, 32'h00000000, 32'h3F800000, 1'b0, 1'b0);
    set_vec(17, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b1);
    set_vec(18, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    vsub[18] = 1'b1;
    set_vec(19, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub_v = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_flags", {ovf, zero}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    send(0);
    @(negedge clk); check_eq("lat_c1", out_valid, 1'b0);
    @(negedge clk); check_eq("lat_c2", out_valid, 1'b0);
    @(negedge clk); check_eq("lat_c3", out_valid, 1'b1);
    @(posedge clk); #1;

    rdy_mode = 1;
    for (int i = 0; i < NV; i++) send(i);
    drain();
    rdy_mode = 0;

    stall_lo = cyc + 4;
    stall_hi = cyc + 8;
    rdy_mode = 2;
    send(0); send(5); send(6); send(14); send(10);
    drain();
    rdy_mode = 0;

    send(5); send(6); send(14);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_valid", out_valid, 1'b0);
    check_eq("rst_async_result", result, 32'h0);
    check_eq("rst_async_in_ready", in_ready, 1'b1);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("post_rst_idle", out_valid, 1'b0);
    end
    @(posedge clk); #1;
    send(1);
    drain();

`ifdef FPADD_SUB_EN
    send(18);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
